// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder datapath.
//   bm_width(n_out, q) : bits needed for a branch metric summed over n_out lanes of q-bit soft data
//   SOFT_MAX(q)        : strongest '1' soft value for q-bit samples
//   soft_sample_t      : container wide enough for any supported soft sample
package viterbi_pkg;

    localparam int SOFT_W_MAX = 8;

    typedef logic [SOFT_W_MAX-1:0] soft_sample_t;

    function automatic int SOFT_MAX(input int q);
        return (1 << q) - 1;
    endfunction

    function automatic int bm_width(input int n_out, input int q);
        return $clog2(n_out * SOFT_MAX(q) + 1);
    endfunction

endpackage

// File: rtl/bmu_soft_if.sv
// Symbol-in / metrics-out handshake bundle for the branch-metric unit.
//   in_valid/in_ready/in_soft/in_last[/in_erase] : symbol from the demapper
//   out_valid/out_ready/out_bm/out_best/out_last : metrics to the ACS array
//   in_erase exists only when BMU_PUNCTURE_EN is defined.
// master = demapper/ACS side, slave = branch-metric unit.
interface bmu_soft_if #(
    parameter int N_OUT = 2,
    parameter int Q     = 3
);
    import viterbi_pkg::*;

    localparam int BM_W  = bm_width(N_OUT, Q);
    localparam int N_HYP = 1 << N_OUT;

    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*Q-1:0]      in_soft;
    logic                    in_last;
`ifdef BMU_PUNCTURE_EN
    logic [N_OUT-1:0]        in_erase;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic [N_HYP*BM_W-1:0]   out_bm;
    logic [N_OUT-1:0]        out_best;
    logic                    out_last;

`ifdef BMU_PUNCTURE_EN
    modport master (
        output in_valid, in_soft, in_last, in_erase, out_ready,
        input  in_ready, out_valid, out_bm, out_best, out_last
    );
    modport slave (
        input  in_valid, in_soft, in_last, in_erase, out_ready,
        output in_ready, out_valid, out_bm, out_best, out_last
    );
`else
    modport master (
        output in_valid, in_soft, in_last, out_ready,
        input  in_ready, out_valid, out_bm, out_best, out_last
    );
    modport slave (
        input  in_valid, in_soft, in_last, out_ready,
        output in_ready, out_valid, out_bm, out_best, out_last
    );
`endif

endinterface

// File: rtl/bmu_lane.sv
// Per-lane soft distance, purely combinational.
//   s     : soft sample (0 = strong '0', SOFT_MAX = strong '1')
//   erase : punctured lane, both distances forced to 0
//   d0/d1 : distance to expected bit 0 / expected bit 1
module bmu_lane
    import viterbi_pkg::*;
#(
    parameter int Q = 3
) (
    input  logic [Q-1:0] s,
    input  logic         erase,
    output logic [Q-1:0] d0,
    output logic [Q-1:0] d1
);

    always_comb begin
        d0 = '0;
        d1 = '0;
        if (!erase) begin
            d0 = s;
            d1 = Q'(SOFT_MAX(Q)) - s;
        end
    end

endmodule

// File: rtl/bmu_soft.sv
// Pipelined branch-metric unit, rate 1/N_OUT, latency 2, one symbol per cycle.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : bmu_soft_if.slave (symbol in, metrics + best hypothesis out)
//   sym_cnt  : symbols accepted since reset or the last out_last handshake
// Build macro BMU_PUNCTURE_EN enables the per-lane erasure input.
module bmu_soft
    import viterbi_pkg::*;
#(
    parameter int N_OUT = 2,
    parameter int Q     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bmu_soft_if.slave        bus,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam int BM_W  = bm_width(N_OUT, Q);
    localparam int N_HYP = 1 << N_OUT;

    logic [Q-1:0]      lane_d0 [N_OUT];
    logic [Q-1:0]      lane_d1 [N_OUT];
    logic [N_OUT-1:0]  erase;

    logic              s1_v_q, s1_v_d;
    logic              s1_last_q, s1_last_d;
    logic [Q-1:0]      d0_q [N_OUT];
    logic [Q-1:0]      d0_d [N_OUT];
    logic [Q-1:0]      d1_q [N_OUT];
    logic [Q-1:0]      d1_d [N_OUT];

    logic              s2_v_q, s2_v_d;
    logic              last_q, last_d;
    logic [BM_W-1:0]   bm_q [N_HYP];
    logic [BM_W-1:0]   bm_d [N_HYP];
    logic [N_OUT-1:0]  best_q, best_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              s1_adv, s2_adv, in_hs, out_hs;
    logic [BM_W-1:0]   sum [N_HYP];
    logic [BM_W-1:0]   best_val;
    logic [N_OUT-1:0]  best_idx;

`ifdef BMU_PUNCTURE_EN
    assign erase = bus.in_erase;
`else
    assign erase = '0;
`endif

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        bmu_lane #(.Q(Q)) u_lane (
            .s     (bus.in_soft[k*Q +: Q]),
            .erase (erase[k]),
            .d0    (lane_d0[k]),
            .d1    (lane_d1[k])
        );
    end

    // No skid buffer: in_ready ripples combinationally from out_ready.
    assign s2_adv = !s2_v_q || bus.out_ready;
    assign s1_adv = !s1_v_q || s2_adv;
    assign in_hs  = bus.in_valid && s1_adv;
    assign out_hs = s2_v_q && bus.out_ready;

    // Hypothesis sums from the registered lane distances; strict '<' keeps the
    // lowest index on ties.
    always_comb begin
        best_val = '0;
        best_idx = '0;
        for (int h = 0; h < N_HYP; h++) begin
            sum[h] = '0;
            for (int k = 0; k < N_OUT; k++) begin
                sum[h] = sum[h] + BM_W'(((h >> k) & 1) != 0 ? d1_q[k] : d0_q[k]);
            end
            if (h == 0 || sum[h] < best_val) begin
                best_val = sum[h];
                best_idx = N_OUT'(h);
            end
        end
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_last_d = s1_last_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        s2_v_d    = s2_v_q;
        last_d    = last_q;
        bm_d      = bm_q;
        best_d    = best_q;
        cnt_d     = cnt_q;

        if (s1_adv) s1_v_d = bus.in_valid;
        if (in_hs) begin
            d0_d      = lane_d0;
            d1_d      = lane_d1;
            s1_last_d = bus.in_last;
        end

        if (s2_adv) s2_v_d = s1_v_q;
        if (s2_adv && s1_v_q) begin
            bm_d   = sum;
            best_d = best_idx;
            last_d = s1_last_q;
        end

        // Frame-end clear takes priority; a symbol accepted in the same cycle
        // becomes the first of the new frame.
        if (out_hs && last_q) cnt_d = in_hs ? CNT_W'(1) : '0;
        else if (in_hs)       cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            d0_q      <= '{default: '0};
            d1_q      <= '{default: '0};
            s2_v_q    <= 1'b0;
            last_q    <= 1'b0;
            bm_q      <= '{default: '0};
            best_q    <= '0;
            cnt_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            s2_v_q    <= s2_v_d;
            last_q    <= last_d;
            bm_q      <= bm_d;
            best_q    <= best_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.out_best  = best_q;
    assign bus.out_last  = last_q;
    assign sym_cnt       = cnt_q;

    for (genvar h = 0; h < N_HYP; h++) begin : g_bm
        assign bus.out_bm[h*BM_W +: BM_W] = bm_q[h];
    end

endmodule
